reg_timeout_guard: RTL and testbench



---
 rtl/reg_timeout_guard_pkg.sv | 21 ++
 rtl/reg_timeout_guard.sv | 120 ++++++++++++
 tb/tb_reg_timeout_guard.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_timeout_guard_pkg.sv
// Shared register-bus types and the common error-response pattern used by
// every bus error responder in this slice.
package reg_timeout_guard_pkg;

    localparam logic [31:0] REG_BUS_ERR_RDATA = 32'hBADC_AB1E;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_bus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_bus_rsp_t;

endpackage

// File: rtl/reg_timeout_guard.sv
// Register-bus watchdog: forwards requests unchanged and completes a stalled
// request with an error response once the peripheral exceeds TimeoutCycles.
module reg_timeout_guard
    import reg_timeout_guard_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255,
    parameter logic [31:0] ErrRdata      = REG_BUS_ERR_RDATA,
    parameter type         req_t         = reg_bus_req_t,
    parameter type         rsp_t         = reg_bus_rsp_t,
    parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  req_t       src_req_i,
    output rsp_t       src_rsp_o,
    output req_t       dst_req_o,
    input  rsp_t       dst_rsp_i,
    output logic       timeout_o,
    output logic [7:0] timeout_cnt_o,
    input  logic       clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] CNT_LAST = CntWidth'(TimeoutCycles - 1);

    state_e              state_r;
    state_e              state_next_s;
    logic [CntWidth-1:0] cnt_r;
    logic [CntWidth-1:0] cnt_next_s;
    logic                stall_s;
    logic                timeout_r;
    logic [7:0]          timeout_cnt_r;

    assign stall_s = src_req_i.valid & ~dst_rsp_i.ready;

    // State and stall-cycle counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; Idle and Wait share the stall test so TimeoutCycles=1 needs no special case
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = '0;
        case (state_r)
            ST_IDLE, ST_WAIT: begin
                if (!stall_s) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_RESPOND;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = ST_WAIT;
                    cnt_next_s   = cnt_r + CntWidth'(1);
                end
            end
            ST_RESPOND: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Bus outputs: transparent except for the single error-completion cycle
    always_comb begin
        dst_req_o = src_req_i;
        src_rsp_o = dst_rsp_i;
        if (state_r == ST_RESPOND) begin
            dst_req_o.valid = 1'b0;
            src_rsp_o.ready = 1'b1;
            src_rsp_o.error = 1'b1;
            src_rsp_o.rdata = ErrRdata;
        end else begin
            dst_req_o = src_req_i;
            src_rsp_o = dst_rsp_i;
        end
    end

    // Timeout pulse is registered so it lines up with the Respond cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= (state_next_s == ST_RESPOND);
        end
    end

    // Saturating timeout event counter; clear takes priority over increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_cnt_r <= 8'd0;
        end else if (clr_i) begin
            timeout_cnt_r <= 8'd0;
        end else if ((state_r == ST_RESPOND) && (timeout_cnt_r != 8'hFF)) begin
            timeout_cnt_r <= timeout_cnt_r + 8'd1;
        end else begin
            timeout_cnt_r <= timeout_cnt_r;
        end
    end

    assign timeout_o     = timeout_r;
    assign timeout_cnt_o = timeout_cnt_r;

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Self-checking bench for reg_timeout_guard: vector table plus multi-cycle
// sequences, with per-cycle expectations queued and checked at the falling edge.
module tb_reg_timeout_guard;
    import reg_timeout_guard_pkg::*;

    localparam int unsigned T = 8;
    localparam logic [31:0] ERR = 32'hBADC_AB1E;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] addr;
        logic        dready;
        logic [31:0] drdata;
        logic        clr;
        logic        rst;
        logic        e_dvalid;
        logic        e_rdy;
        logic        e_err;
        logic [31:0] e_rdata;
        logic        e_to;
        logic [7:0]  e_tcnt;
        logic        chk1;
        logic        e1_dv;
        logic        e1_rdy;
        logic        e1_to;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    reg_bus_req_t src_req;
    reg_bus_rsp_t dst_rsp;
    reg_bus_req_t dst_req, dst_req1;
    reg_bus_rsp_t src_rsp, src_rsp1;
    logic         to, to1;
    logic [7:0]   tcnt, tcnt1;

    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] exp_tcnt = 8'd0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    reg_timeout_guard #(.TimeoutCycles(T)) dut (
        .clk_i(clk), .rst_i(rst), .src_req_i(src_req), .src_rsp_o(src_rsp),
        .dst_req_o(dst_req), .dst_rsp_i(dst_rsp), .timeout_o(to),
        .timeout_cnt_o(tcnt), .clr_i(clr)
    );

    reg_timeout_guard #(.TimeoutCycles(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .src_req_i(src_req), .src_rsp_o(src_rsp1),
        .dst_req_o(dst_req1), .dst_rsp_i(dst_rsp), .timeout_o(to1),
        .timeout_cnt_o(tcnt1), .clr_i(clr)
    );

    function automatic vec_t mk(string n, logic v, logic r, logic [31:0] rd, logic c, logic rs,
                                logic edv, logic erdy, logic eerr, logic [31:0] erd,
                                logic eto, logic [7:0] etc);
        vec_t x;
        x.name = n; x.valid = v; x.addr = 32'h0000_0010; x.dready = r; x.drdata = rd;
        x.clr = c; x.rst = rs; x.e_dvalid = edv; x.e_rdy = erdy; x.e_err = eerr;
        x.e_rdata = erd; x.e_to = eto; x.e_tcnt = etc;
        x.chk1 = 1'b0; x.e1_dv = 1'b0; x.e1_rdy = 1'b0; x.e1_to = 1'b0;
        return x;
    endfunction

    function automatic vec_t stall(string n);
        return mk(n, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, exp_tcnt);
    endfunction

    function automatic vec_t pass(string n, logic [31:0] rd);
        return mk(n, 1'b1, 1'b1, rd, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rd, 1'b0, exp_tcnt);
    endfunction

    function automatic vec_t idlev(string n);
        return mk(n, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, exp_tcnt);
    endfunction

    function automatic vec_t resp(string n, logic late, logic c);
        return mk(n, 1'b1, late, late ? 32'h5555_5555 : 32'h0, c, 1'b0,
                  1'b0, 1'b1, 1'b1, ERR, 1'b1, exp_tcnt);
    endfunction

    task automatic check();
        vec_t e;
        e = sb.pop_front();
        n_vec++;
        if (dst_req.valid !== e.e_dvalid || dst_req.addr !== e.addr ||
            src_rsp.ready !== e.e_rdy || src_rsp.error !== e.e_err ||
            src_rsp.rdata !== e.e_rdata || to !== e.e_to || tcnt !== e.e_tcnt) begin
            n_err++;
            $display("FAIL %s: got dv=%b addr=%h rdy=%b err=%b rdata=%h to=%b tcnt=%0d, want dv=%b addr=%h rdy=%b err=%b rdata=%h to=%b tcnt=%0d",
                     e.name, dst_req.valid, dst_req.addr, src_rsp.ready, src_rsp.error,
                     src_rsp.rdata, to, tcnt, e.e_dvalid, e.addr, e.e_rdy, e.e_err,
                     e.e_rdata, e.e_to, e.e_tcnt);
        end
        if (e.chk1) begin
            n_vec++;
            if (dst_req1.valid !== e.e1_dv || src_rsp1.ready !== e.e1_rdy ||
                src_rsp1.error !== e.e1_rdy || to1 !== e.e1_to) begin
                n_err++;
                $display("FAIL %s/t1: got dv=%b rdy=%b err=%b to=%b, want dv=%b rdy=%b err=%b to=%b",
                         e.name, dst_req1.valid, src_rsp1.ready, src_rsp1.error, to1,
                         e.e1_dv, e.e1_rdy, e.e1_rdy, e.e1_to);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        src_req.valid = v.valid;
        src_req.addr  = v.addr;
        src_req.write = 1'b0;
        src_req.wdata = 32'hA5A5_0000;
        src_req.wstrb = 4'hF;
        dst_rsp.ready = v.dready;
        dst_rsp.rdata = v.drdata;
        dst_rsp.error = 1'b0;
        clr = v.clr;
        rst = v.rst;
        sb.push_back(v);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_seq(input logic late, input logic c);
        for (int i = 0; i < T; i++) apply(stall($sformatf("to_stall%0d", i)));
        apply(resp("to_resp", late, c));
        exp_tcnt = c ? 8'd0 : ((exp_tcnt == 8'hFF) ? 8'hFF : exp_tcnt + 8'd1);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; clr = 1'b0; src_req = '0; dst_rsp = '0;

        tbl.push_back(mk("rst_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                         1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0));
        tbl.push_back(mk("rst_pass", 1'b1, 1'b1, 32'h77, 1'b0, 1'b1,
                         1'b1, 1'b1, 1'b0, 32'h77, 1'b0, 8'd0));
        tbl.push_back(idlev("idle0"));
        for (int i = 0; i < 3; i++) tbl.push_back(stall($sformatf("rd_c%0d", i)));
        tbl.push_back(pass("rd_c3", 32'h0000_1234));
        tbl.push_back(idlev("rd_done"));
        for (int i = 0; i < 10; i++) begin
            v = pass($sformatf("b2b%0d", i), 32'h100 + i);
            v.addr = 32'h200 + 4 * i;
            tbl.push_back(v);
        end
        for (int i = 0; i < T - 1; i++) tbl.push_back(stall($sformatf("late_c%0d", i)));
        tbl.push_back(pass("late_ready_c7", 32'h0000_CAFE));
        tbl.push_back(idlev("late_done"));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // Timeout with a late ready in the Respond cycle, then count visible
        timeout_seq(1'b1, 1'b0);
        apply(idlev("after_to1"));

        // New request right after Respond gets a full window
        timeout_seq(1'b0, 1'b0);
        timeout_seq(1'b0, 1'b0);
        apply(idlev("after_b2b_to"));

        // Saturation, clear, and clear versus simultaneous increment
        for (int k = 0; k < 260; k++) begin
            timeout_seq(1'b0, 1'b0);
            apply(idlev("sat_gap"));
        end
        apply(mk("clr_pulse", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd255));
        exp_tcnt = 8'd0;
        apply(idlev("after_clr"));
        timeout_seq(1'b0, 1'b0);
        apply(idlev("one_to"));
        timeout_seq(1'b0, 1'b1);
        apply(idlev("clr_wins"));

        // Reset in the middle of a stall
        for (int i = 0; i < 5; i++) apply(stall($sformatf("rst_pre%0d", i)));
        for (int i = 0; i < 2; i++)
            apply(mk("rst_mid", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1,
                     1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0));
        timeout_seq(1'b0, 1'b0);
        apply(idlev("rst_done"));

        // Valid dropped mid-stall restarts the window
        for (int i = 0; i < 4; i++) apply(stall($sformatf("drop_a%0d", i)));
        apply(idlev("drop_gap0"));
        apply(idlev("drop_gap1"));
        timeout_seq(1'b0, 1'b0);
        apply(idlev("drop_done"));

        // TimeoutCycles = 1 instance: first-cycle stall answers next cycle
        apply(idlev("t1_idle"));
        v = stall("t1_c0");
        v.chk1 = 1'b1; v.e1_dv = 1'b1; v.e1_rdy = 1'b0; v.e1_to = 1'b0;
        apply(v);
        v = stall("t1_c1");
        v.chk1 = 1'b1; v.e1_dv = 1'b0; v.e1_rdy = 1'b1; v.e1_to = 1'b1;
        apply(v);
        v = idlev("t1_c2");
        v.chk1 = 1'b1; v.e1_dv = 1'b0; v.e1_rdy = 1'b0; v.e1_to = 1'b0;
        apply(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
